machine_div_inverse: RTL and testbench

Inverse of the three-stage arithmetic machine: takes a product F and its multiplier D and recovers the intermediate X3 = F / D, plus the remainder. It is an iterative restoring divider that produces one quotient bit per clock. Valid/ready handshakes on both sides let it sit directly downstream of the forward machine, or in a checker that compares recovered X3 against (A+B)+(C-D).

---
 rtl/machine_div_inverse.sv | 168 ++++++++++++++++
 tb/tb_machine_div_inverse.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/machine_div_inverse.sv
// machine_div_inverse
//   Iterative restoring divider that recovers X3 = F / D (and F % D) from the
//   product F and multiplier D of the forward arithmetic machine. One quotient
//   bit is produced per clock; valid/ready handshakes on both sides.
//
// Parameters:
//   N          operand / result width (default 16)
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        synchronous reset, active-high
//   in_valid   F_in/D_in hold a request
//   in_ready   block can accept a request (IDLE only)
//   F_in       dividend, unsigned
//   D_in       divisor, unsigned
//   out_valid  Q/R/div_zero hold a result (DONE only)
//   out_ready  consumer accepts the result
//   Q          quotient
//   R          remainder
//   div_zero   request had D_in == 0
//
// Optional feature macro: DIV_ZERO_FAST_EN
//   Defined: a zero-divisor request bypasses the N shift steps and its result
//   (Q = all ones, R = F_in, div_zero = 1) is presented one edge after accept.
//   Undefined: zero-divisor requests run all N steps like any other request.

module machine_div_inverse #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] F_in,
  input  logic [N-1:0] D_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]  dvd;
  logic [N-1:0]  dsr;
  logic [N-1:0]  rem;
  logic [N-1:0]  quo;
  logic [CW-1:0] cnt;
  logic          dz;

  logic [N:0]    rem_sh;
  logic [N:0]    diff;
  logic          ge;
  logic [N-1:0]  rem_step;
  logic [N-1:0]  quo_step;
  logic          last_step;

  // One restoring step. rem < divisor holds between steps (and rem only ever
  // holds the top dividend bits when the divisor is zero), so rem_sh never
  // exceeds 2*divisor and the borrow bit of the N+1-bit subtract is exactly
  // the "rem_sh < divisor" condition.
  always_comb begin
    rem_sh   = {rem, dvd[N-1]};
    diff     = rem_sh - {1'b0, dsr};
    ge       = ~diff[N];
    rem_step = ge ? diff[N-1:0] : rem_sh[N-1:0];
    quo_step = {quo[N-2:0], ge};
  end

  // cnt == N marks the extra RUN cycle that publishes the result registers.
  assign last_step = (cnt == CW'(N));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      dz       <= 1'b0;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd <= F_in;
            dsr <= D_in;
            rem <= '0;
            quo <= '0;
            cnt <= '0;
            dz  <= (D_in == '0);
`ifdef DIV_ZERO_FAST_EN
            // Preload the final zero-divisor result and jump to the publish
            // cycle, so the result appears one edge after accept.
            if (D_in == '0) begin
              rem <= F_in;
              quo <= '1;
              cnt <= CW'(N);
            end
`endif
          end
        end
        RUN: begin
          if (last_step) begin
            Q        <= quo;
            R        <= rem;
            div_zero <= dz;
          end else begin
            dvd <= dvd << 1;
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_machine_div_inverse.sv
// Testbench for machine_div_inverse: table-driven requests checked through a
// scoreboard, plus hand sequences for back-to-back, stall and mid-run reset.

module tb_machine_div_inverse;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] F_in;
  logic [N-1:0] D_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         div_zero;

  machine_div_inverse #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .F_in      (F_in),
    .D_in      (D_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] f;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  vec_t cur_exp;
  logic prev_valid = 1'b0;
  int   last_acc   = -1;
  logic last_dz    = 1'b0;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      last_acc   = -1;
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_t e;
        if (last_acc >= 0 && !(last_dz && FAST))
          chk("accept_spacing_ge_18", (cyc - last_acc >= N + 2) ? 1 : 0, 1);
        e.v = cur_exp;
        e.acc = cyc;
        sb.push_back(e);
        last_acc = cyc;
        last_dz  = cur_exp.dz;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          if (!prev_valid)
            chk("latency", cyc - sb[0].acc, (sb[0].v.dz && FAST) ? 2 : N + 2);
          chk("Q", int'(Q), int'(sb[0].v.q));
          chk("R", int'(R), int'(sb[0].v.r));
          chk("div_zero", int'(div_zero), int'(sb[0].v.dz));
          chk("in_ready_low_in_done", int'(in_ready), 0);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_Q", int'(Q), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_div_zero", int'(div_zero), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  task automatic send(input vec_t v, input bit hold);
    bit acc = 1'b0;
    cur_exp  = v;
    F_in     = v.f;
    D_in     = v.d;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (in_ready) begin
        acc = 1'b1;
        tick(1);
        break;
      end
      tick(1);
    end
    if (!acc) chk("accept_timeout", 0, 1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    bit ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      tick(1);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("result_timeout", 0, 1);
  endtask

  vec_t tbl[$];
  vec_t b2b[$];
  vec_t v;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    F_in      = '0;
    D_in      = '0;
    tick(1);
    do_reset();

    tbl.push_back('{f:16'd75,    d:16'd3,    q:16'd25,    r:16'd0,    dz:1'b0});
    tbl.push_back('{f:16'd5,     d:16'd9,    q:16'd0,     r:16'd5,    dz:1'b0});
    tbl.push_back('{f:16'd9,     d:16'd9,    q:16'd1,     r:16'd0,    dz:1'b0});
    tbl.push_back('{f:16'hFFFF,  d:16'd1,    q:16'hFFFF,  r:16'd0,    dz:1'b0});
    tbl.push_back('{f:16'h1234,  d:16'd0,    q:16'hFFFF,  r:16'h1234, dz:1'b1});
    tbl.push_back('{f:16'd0,     d:16'd5,    q:16'd0,     r:16'd0,    dz:1'b0});
    tbl.push_back('{f:16'hFFFF,  d:16'hFFFF, q:16'd1,     r:16'd0,    dz:1'b0});
    tbl.push_back('{f:16'd1,     d:16'hFFFF, q:16'd0,     r:16'd1,    dz:1'b0});
    tbl.push_back('{f:16'h8000,  d:16'd3,    q:16'h2AAA,  r:16'd2,    dz:1'b0});
    tbl.push_back('{f:16'd1000,  d:16'd33,   q:16'd30,    r:16'd10,   dz:1'b0});
    tbl.push_back('{f:16'hFFFF,  d:16'h8000, q:16'd1,     r:16'h7FFF, dz:1'b0});

    foreach (tbl[i]) begin
      send(tbl[i], 1'b0);
      wait_empty();
      chk("in_ready_after_handshake", int'(in_ready), 1);
    end

    // Back-to-back with in_valid held high throughout.
    b2b.push_back('{f:16'd66,  d:16'd3, q:16'd22, r:16'd0, dz:1'b0});
    b2b.push_back('{f:16'd112, d:16'd4, q:16'd28, r:16'd0, dz:1'b0});
    b2b.push_back('{f:16'd62,  d:16'd2, q:16'd31, r:16'd0, dz:1'b0});
    b2b.push_back('{f:16'd116, d:16'd4, q:16'd29, r:16'd0, dz:1'b0});
    foreach (b2b[i]) send(b2b[i], (i != b2b.size() - 1));
    wait_empty();

    // Output stall: Q/R held while out_ready is low (monitor checks each cycle).
    out_ready = 1'b0;
    v = '{f:16'd100, d:16'd7, q:16'd14, r:16'd2, dz:1'b0};
    send(v, 1'b0);
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
        tick(1);
      end
      if (!seen) chk("stall_out_valid_timeout", 0, 1);
    end
    tick(5);
    chk("stall_still_valid", int'(out_valid), 1);
    chk("stall_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    wait_empty();
    chk("stall_in_ready_after", int'(in_ready), 1);

    // Reset at step 8 of 66/3: request abandoned, then a fresh 75/3.
    v = '{f:16'd66, d:16'd3, q:16'd22, r:16'd0, dz:1'b0};
    send(v, 1'b0);
    tick(7);
    do_reset();
    tick(N + 6);
    chk("abandoned_no_valid", int'(out_valid), 0);
    v = '{f:16'd75, d:16'd3, q:16'd25, r:16'd0, dz:1'b0};
    send(v, 1'b0);
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
